// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared constants for the seven-segment scanner
// Purpose: hex-to-segment glyph table, blank pattern and digit limit.
// Segment bit order is CA..CG on bits 0..6, active-low (0 = segment lit).
package sevenseg_pkg;

   localparam int MAX_DIGITS = 8;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   localparam logic [6:0] HEX_SEG_TABLE [16] = '{
      7'h40,   // 0
      7'h79,   // 1
      7'h24,   // 2
      7'h30,   // 3
      7'h19,   // 4
      7'h12,   // 5
      7'h02,   // 6
      7'h78,   // 7
      7'h00,   // 8
      7'h10,   // 9
      7'h08,   // A
      7'h03,   // b
      7'h46,   // C
      7'h21,   // d
      7'h06,   // E
      7'h0E    // F
   };

endpackage

// File: rtl/sevenseg_scan_if.sv
// rtl/sevenseg_scan_if.sv - control/data and display pin bundle for sevenseg_scan
// Purpose: groups the scanner's control inputs and display outputs.
// Signals:
//   enable     - 1 = scanning, 0 = dark with counters held at 0
//   load       - single-cycle strobe capturing data_in/dp_in
//   data_in    - 32-bit value, nibble k drives digit k
//   dp_in      - per-digit decimal point request, 1 = lit
//   an         - digit anodes, active-low
//   seg        - cathodes CA..CG, active-low
//   dp         - decimal point cathode, active-low
//   frame_done - one-cycle pulse when the last digit slot ends
// Modports: master drives control, slave is the scanner.
interface sevenseg_scan_if #(
   parameter int DIGITS = 8
);
   logic              enable;
   logic              load;
   logic [31:0]       data_in;
   logic [DIGITS-1:0] dp_in;
   logic [DIGITS-1:0] an;
   logic [6:0]        seg;
   logic              dp;
   logic              frame_done;

   modport master (
      output enable, load, data_in, dp_in,
      input  an, seg, dp, frame_done
   );

   modport slave (
      input  enable, load, data_in, dp_in,
      output an, seg, dp, frame_done
   );
endinterface

// File: rtl/hex7seg_decode.sv
// rtl/hex7seg_decode.sv - combinational hex nibble to active-low segment decode
// Purpose: table lookup of the 0-F glyphs (A, b, C, d, E, F for 10-15).
// Ports:
//   i_nibble - 4-bit hex value
//   o_seg    - segments CA..CG on bits 0..6, active-low
module hex7seg_decode
   import sevenseg_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = HEX_SEG_TABLE[i_nibble];

endmodule

// File: rtl/sevenseg_scan.sv
// rtl/sevenseg_scan.sv - time-multiplexed hex display scanner with tear-free update
// Purpose: scans DIGITS hex digits, REFRESH_DIV cycles per digit, with the
// first BLANK_CYC cycles of every slot dark to suppress ghosting. New data is
// staged in a shadow register and only reaches the display at frame wrap.
// Optional build macro: SEVENSEG_LZB_EN enables leading-zero blanking.
// Ports:
//   i_clk   - system clock, rising edge
//   i_rst   - asynchronous active-high reset
//   io_disp - sevenseg_scan_if slave: enable/load/data_in/dp_in in,
//             an/seg/dp (registered, active-low) and frame_done out
module sevenseg_scan
   import sevenseg_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_CYC   = 16,
   parameter int DIGITS      = 8
) (
   input  logic           i_clk,
   input  logic           i_rst,
   sevenseg_scan_if.slave io_disp
);

   localparam int             PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0]  BLANK_END  = PW'(BLANK_CYC);
   localparam logic [2:0]     IDX_LAST   = 3'(DIGITS - 1);

   logic [PW-1:0]     r_presc;
   logic [2:0]        r_idx;
   logic [31:0]       r_shadow_data;
   logic [DIGITS-1:0] r_shadow_dp;
   logic [31:0]       r_disp_data;
   logic [DIGITS-1:0] r_disp_dp;
   logic              r_pending;
   logic [DIGITS-1:0] r_an;
   logic [6:0]        r_seg;
   logic              r_dp;
   logic              r_frame_done;

   logic                  w_presc_tc;
   logic                  w_wrap;
   logic                  w_blank_slot;
   logic                  w_lz_blank;
   logic [3:0]            w_nib;
   logic [6:0]            w_seg_dec;
   logic [MAX_DIGITS-1:0] w_dp_full;
   logic                  w_dp_sel;
   logic [DIGITS-1:0]     w_an_next;
   logic [6:0]            w_seg_next;
   logic                  w_dp_next;

   assign w_presc_tc   = (r_presc == PRESC_LAST);
   // The wrap cycle is the last cycle of the last digit slot.
   assign w_wrap       = io_disp.enable && w_presc_tc && (r_idx == IDX_LAST);
   assign w_blank_slot = (r_presc < BLANK_END);
   assign w_nib        = r_disp_data[{r_idx, 2'b00} +: 4];
   assign w_dp_full    = MAX_DIGITS'(r_disp_dp);
   assign w_dp_sel     = w_dp_full[r_idx];

   hex7seg_decode u_decode (
      .i_nibble (w_nib),
      .o_seg    (w_seg_dec)
   );

   // Prescaler and digit index; both parked at 0 while disabled so that
   // re-enabling always starts a fresh frame at digit 0.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_presc <= '0;
         r_idx   <= '0;
      end else if (!io_disp.enable) begin
         r_presc <= '0;
         r_idx   <= '0;
      end else if (w_presc_tc) begin
         r_presc <= '0;
         r_idx   <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   // A load landing in the wrap cycle bypasses the shadow; otherwise the
   // shadow holds the latest load until the frame wraps.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_shadow_data <= '0;
         r_shadow_dp   <= '0;
         r_disp_data   <= '0;
         r_disp_dp     <= '0;
         r_pending     <= 1'b0;
      end else if (io_disp.load && w_wrap) begin
         r_disp_data <= io_disp.data_in;
         r_disp_dp   <= io_disp.dp_in;
         r_pending   <= 1'b0;
      end else if (io_disp.load) begin
         r_shadow_data <= io_disp.data_in;
         r_shadow_dp   <= io_disp.dp_in;
         r_pending     <= 1'b1;
      end else if (w_wrap && r_pending) begin
         r_disp_data <= r_shadow_data;
         r_disp_dp   <= r_shadow_dp;
         r_pending   <= 1'b0;
      end
   end

`ifdef SEVENSEG_LZB_EN
   logic [2:0] w_lz_hi;

   // Highest digit holding a non-zero nibble; digit 0 is the floor so it is
   // always shown. A lit decimal point keeps its digit visible.
   always_comb begin
      w_lz_hi = 3'd0;
      for (int k = 1; k < DIGITS; k++) begin
         if (r_disp_data[4*k +: 4] != 4'h0) begin
            w_lz_hi = 3'(k);
         end
      end
      w_lz_blank = (r_idx > w_lz_hi) && !w_dp_sel;
   end
`else
   assign w_lz_blank = 1'b0;
`endif

   always_comb begin
      w_an_next  = '1;
      w_seg_next = SEG_OFF;
      w_dp_next  = 1'b1;
      if (io_disp.enable && !w_blank_slot && !w_lz_blank) begin
         for (int k = 0; k < DIGITS; k++) begin
            w_an_next[k] = (r_idx != 3'(k));
         end
         w_seg_next = w_seg_dec;
         w_dp_next  = ~w_dp_sel;
      end
   end

   // Pin drivers are registered, so they trail the counter state by one cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_an         <= '1;
         r_seg        <= SEG_OFF;
         r_dp         <= 1'b1;
         r_frame_done <= 1'b0;
      end else begin
         r_an         <= w_an_next;
         r_seg        <= w_seg_next;
         r_dp         <= w_dp_next;
         r_frame_done <= w_wrap;
      end
   end

   assign io_disp.an         = r_an;
   assign io_disp.seg        = r_seg;
   assign io_disp.dp         = r_dp;
   assign io_disp.frame_done = r_frame_done;

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb/tb_sevenseg_scan.sv - self-checking bench for sevenseg_scan
// Purpose: table vectors, corner sequences and random traffic against a
// frame-level model (REFRESH_DIV=4, BLANK_CYC=1, DIGITS=8, 32-cycle frame).
module tb_sevenseg_scan;

   localparam int FRAME = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   sevenseg_scan_if #(.DIGITS(8)) u_if ();

   sevenseg_scan #(
      .REFRESH_DIV (4),
      .BLANK_CYC   (1),
      .DIGITS      (8)
   ) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .io_disp (u_if)
   );

`ifdef SEVENSEG_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   localparam logic [6:0] GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef struct {
      logic [31:0] data;
      logic [7:0]  dpv;
      int          digit;
      logic [7:0]  an;
      logic [6:0]  seg;
      logic        dp;
   } vec_t;

   vec_t vecs [12];

   int n_cmp = 0;
   int n_err = 0;

   // Frame-level model: m_n counts enabled cycles since the frame origin.
   int          m_n = 0;
   bit          m_en = 1'b0;
   logic [31:0] m_disp = '0;
   logic [31:0] m_shadow = '0;
   logic [7:0]  m_disp_dp = '0;
   logic [7:0]  m_shadow_dp = '0;
   bit          m_pend = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit lz_blank(input int idx);
      int hi = 0;
      for (int k = 0; k < 8; k++) begin
         if (((m_disp >> (4 * k)) & 32'hF) != 0) hi = k;
      end
      return LZB && (idx > hi) && !m_disp_dp[idx];
   endfunction

   // One clock: drive inputs, predict outputs from the model, step model, compare.
   task automatic cyc(input bit ld, input logic [31:0] d, input logic [7:0] p);
      int presc;
      int idx;
      bit wrap;
      logic [7:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      u_if.enable  = m_en;
      u_if.load    = ld;
      u_if.data_in = d;
      u_if.dp_in   = p;
      presc = m_en ? (m_n % 4) : 0;
      idx   = m_en ? ((m_n / 4) % 8) : 0;
      wrap  = m_en && ((m_n % FRAME) == FRAME - 1);
      e_an  = 8'hFF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      if (m_en && presc >= 1 && !lz_blank(idx)) begin
         e_an  = ~(8'd1 << idx);
         e_seg = GLYPH[4'(m_disp >> (4 * idx))];
         e_dp  = ~m_disp_dp[idx];
      end
      if (ld && wrap) begin
         m_disp = d; m_disp_dp = p; m_pend = 1'b0;
      end else if (ld) begin
         m_shadow = d; m_shadow_dp = p; m_pend = 1'b1;
      end else if (wrap && m_pend) begin
         m_disp = m_shadow; m_disp_dp = m_shadow_dp; m_pend = 1'b0;
      end
      m_n = m_en ? m_n + 1 : 0;
      @(posedge clk);
      @(negedge clk);
      u_if.load = 1'b0;
      check("an", 32'(u_if.an), 32'(e_an));
      check("seg", 32'(u_if.seg), 32'(e_seg));
      check("dp", 32'(u_if.dp), 32'(e_dp));
      check("frame_done", 32'(u_if.frame_done), 32'(wrap));
   endtask

   task automatic idle();
      cyc(1'b0, 32'h0, 8'h0);
   endtask

   // Advance until the model's next state sits at frame position pos.
   task automatic advance_to(input int pos);
      for (int i = 0; i < 2 * FRAME && (m_n % FRAME) != pos; i++) idle();
      check("advance_bound", 32'(m_n % FRAME), 32'(pos));
   endtask

   task automatic load_and_wrap(input logic [31:0] d, input logic [7:0] p);
      if ((m_n % FRAME) == FRAME - 1) idle();
      cyc(1'b1, d, p);
      for (int i = 0; i < FRAME && (m_n % FRAME) != 0; i++) idle();
   endtask

   initial begin
      int seen2;
      int all2;
      int blank_ok;
      int t_first;
      int t_second;
      int t;

      vecs[0]  = '{32'h0000_00A5, 8'h00, 0, 8'hFE, 7'h12, 1'b1};
      vecs[1]  = '{32'h0000_00A5, 8'h00, 1, 8'hFD, 7'h08, 1'b1};
      vecs[2]  = '{32'h2222_2222, 8'h00, 5, 8'hDF, 7'h24, 1'b1};
      vecs[3]  = '{32'h0000_0007, 8'h01, 0, 8'hFE, 7'h78, 1'b0};
      vecs[4]  = '{32'hFEDC_BA98, 8'h00, 7, 8'h7F, 7'h0E, 1'b1};
      vecs[5]  = '{32'hFEDC_BA98, 8'h00, 3, 8'hF7, 7'h03, 1'b1};
      vecs[6]  = '{32'h0000_0030, 8'h00, 1, 8'hFD, 7'h30, 1'b1};
`ifdef SEVENSEG_LZB_EN
      vecs[7]  = '{32'h0000_0030, 8'h00, 2, 8'hFF, 7'h7F, 1'b1};
`else
      vecs[7]  = '{32'h0000_0030, 8'h00, 2, 8'hFB, 7'h40, 1'b1};
`endif
      vecs[8]  = '{32'h0000_0030, 8'h04, 2, 8'hFB, 7'h40, 1'b0};
      vecs[9]  = '{32'h0000_0000, 8'h00, 0, 8'hFE, 7'h40, 1'b1};
      vecs[10] = '{32'hC0D0_0000, 8'h00, 5, 8'hDF, 7'h21, 1'b1};
      vecs[11] = '{32'hC0D0_0000, 8'h00, 6, 8'hBF, 7'h40, 1'b1};

      u_if.enable  = 1'b0;
      u_if.load    = 1'b0;
      u_if.data_in = '0;
      u_if.dp_in   = '0;

      repeat (2) @(negedge clk);
      check("rst_an", 32'(u_if.an), 32'hFF);
      check("rst_seg", 32'(u_if.seg), 32'h7F);
      check("rst_dp", 32'(u_if.dp), 32'h1);
      check("rst_fd", 32'(u_if.frame_done), 32'h0);
      rst = 1'b0;

      repeat (3) idle();
      m_en = 1'b1;

      foreach (vecs[v]) begin
         load_and_wrap(vecs[v].data, vecs[v].dpv);
         advance_to(vecs[v].digit * 4 + 2);
         idle();
         check("vec_an", 32'(u_if.an), 32'(vecs[v].an));
         check("vec_seg", 32'(u_if.seg), 32'(vecs[v].seg));
         check("vec_dp", 32'(u_if.dp), 32'(vecs[v].dp));
      end

      // Mid-frame reload must not tear the frame currently on screen.
      load_and_wrap(32'h1111_1111, 8'h00);
      advance_to(10);
      cyc(1'b1, 32'h2222_2222, 8'h00);
      seen2 = 0;
      for (int i = 0; i < FRAME && (m_n % FRAME) != 0; i++) begin
         idle();
         if (u_if.seg == 7'h24) seen2++;
      end
      check("no_tear", 32'(seen2), 32'd0);
      all2 = 0;
      blank_ok = 0;
      for (int i = 0; i < FRAME; i++) begin
         idle();
         if (((m_n - 1) % 4) == 0) begin
            if (u_if.an == 8'hFF) blank_ok++;
         end else begin
            if ($countones(~u_if.an) == 1) blank_ok++;
            if (u_if.seg == 7'h24) all2++;
         end
      end
      check("all_digits_2", 32'(all2), 32'd24);
      check("blank_pattern", 32'(blank_ok), 32'd32);

      // Load in the exact wrap cycle reaches digit 0 in the very next slot.
      advance_to(FRAME - 1);
      cyc(1'b1, 32'h0000_0007, 8'h00);
      idle();
      idle();
      check("wrap_load_an", 32'(u_if.an), 32'hFE);
      check("wrap_load_seg", 32'(u_if.seg), 32'h78);

      // frame_done period.
      t_first = -1;
      t_second = -1;
      for (t = 0; t < 3 * FRAME && t_second < 0; t++) begin
         idle();
         if (u_if.frame_done === 1'b1) begin
            if (t_first < 0) t_first = t;
            else t_second = t;
         end
      end
      check("fd_period", 32'(t_second - t_first), 32'd32);

      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(63) == 0) m_en = !m_en;
         cyc($urandom_range(7) == 0, $urandom, 8'($urandom));
      end
      m_en = 1'b1;
      idle();

      // Reset at digit 5 with a pending update.
      advance_to(21);
      cyc(1'b1, 32'h1234_5678, 8'hFF);
      rst = 1'b1;
      #1;
      check("rst_now_an", 32'(u_if.an), 32'hFF);
      check("rst_now_seg", 32'(u_if.seg), 32'h7F);
      check("rst_now_dp", 32'(u_if.dp), 32'h1);
      check("rst_now_fd", 32'(u_if.frame_done), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      m_n = 0;
      m_disp = '0;
      m_disp_dp = '0;
      m_shadow = '0;
      m_shadow_dp = '0;
      m_pend = 1'b0;
      idle();
      idle();
      check("post_rst_an", 32'(u_if.an), 32'hFE);
      check("post_rst_seg", 32'(u_if.seg), 32'h40);
      repeat (2 * FRAME) idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sevenseg_scan.md
SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit is driven (1 kHz/digit at 50 MHz).
REQ-002 SHALL have parameter BLANK_CYC, default 16, cycles at the start of each digit slot with all anodes off (anti-ghosting); legal range 0 <= BLANK_CYC < REFRESH_DIV.
REQ-003 SHALL have parameter DIGITS, default 8, number of hex digits scanned; legal range 1..8.
REQ-004 clock  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  1 = scanning; 0 = display dark, counters held at 0.
REQ-007 load  input  1  single-cycle strobe capturing data_in and dp_in.
REQ-008 data_in  input  32  value to display; nibble k drives digit k.
REQ-009 dp_in  input  DIGITS  decimal-point request per digit, 1 = lit.
REQ-010 an  output  DIGITS  digit anodes, active-low.
REQ-011 seg  output  7  cathodes CA..CG on bits 0..6, active-low.
REQ-012 dp  output  1  decimal-point cathode, active-low.
REQ-013 frame_done  output  1  one-cycle pulse when the last digit slot ends.

Function
- REQ-014 Prescaler counts 0..REFRESH_DIV-1 while enable=1; at terminal count it wraps to 0 and the digit index advances.
- REQ-015 Digit index counts 0..DIGITS-1, wraps to 0; frame_done=1 for exactly the cycle in which index wraps.
- REQ-016 load stores data_in/dp_in in a shadow register and sets a pending flag; the shadow is copied to the display register in the wrap cycle, clearing pending (no tearing mid-frame).
- REQ-017 load in the wrap cycle: data_in/dp_in go directly to the display register and pending stays clear.
- REQ-018 A second load before the wrap overwrites the shadow; the last value wins.
- REQ-019 an, seg and dp are registered, lagging prescaler/index state by exactly 1 cycle.
- REQ-020 When prescaler < BLANK_CYC: an all 1, seg all 1, dp 1.
- REQ-021 Otherwise: an has only bit [index] at 0; seg = hex decode of display nibble [index]; dp = ~dp_display[index].
- REQ-022 enable=0: prescaler and index forced to 0, frame_done 0, outputs dark the following cycle; load still captures into shadow/pending.
- REQ-023 On enable 0->1 the scan starts at digit 0, prescaler 0 (first BLANK_CYC cycles dark).
- REQ-024 Hex decode covers 0-F (A,b,C,d,E,F glyphs); nibbles above DIGITS-1 are ignored.

Reset
- REQ-025 reset asserted: prescaler 0, index 0, shadow 0, display 0, pending 0, an all 1, seg 7'h7F, dp 1, frame_done 0, taking effect immediately.
- REQ-026 reset mid-frame discards pending data; after release scanning resumes per REQ-023.

Configuration
- REQ-027 Macro SEVENSEG_LZB_EN defined: leading-zero blanking; digits above the highest non-zero display nibble drive an bit 1 and seg all 1; digit 0 is always shown; a digit with dp_display bit 1 is never blanked.
- REQ-028 Macro SEVENSEG_LZB_EN undefined: every digit 0..DIGITS-1 is shown, including zeros.

Structure
- REQ-029 Package sevenseg_pkg SHALL hold the 16-entry hex-to-segment constant table, the SEG_OFF constant (7'h7F) and the maximum digit count (8).
- REQ-030 Combinational sub-module hex7seg_decode (4-bit in, 7-bit active-low out) SHALL perform the decode.

Verification (bench: REFRESH_DIV=4, BLANK_CYC=1, DIGITS=8)
- REQ-031 Reset, enable=1, load data_in=32'h0000_00A5 -> after the first wrap, digit 0 seg=7'h12 ("5") and digit 1 seg=7'h08 ("A"); frame_done pulses every 32 cycles.
- REQ-032 load 32'h1111_1111, then load 32'h2222_2222 mid-frame -> no digit shows 2 before the wrap; every digit shows 2 (seg 7'h24) after the wrap.
- REQ-033 load 32'h0000_0007 in the exact wrap cycle -> digit 0 shows 7 (seg 7'h78) in the very next slot.
- REQ-034 Blank check -> an=8'hFF for cycle 0 of every slot and exactly one an bit low for cycles 1..3.
- REQ-035 With SEVENSEG_LZB_EN, load 32'h0000_0030, dp_in=8'h00 -> digits 2..7 anodes never low, digit 0 shows "0", digit 1 shows "3"; without the macro, digits 2..7 show "0" (seg 7'h40).
- REQ-036 Assert reset at digit 5 with pending set -> outputs dark immediately; after release with enable=1, digit 0 is driven first and shows 0.
